// File: rtl/mem_wb_pipe.sv
// MEM->WB writeback register: LANES lanes move as one bundle; lane writes to address 0 are squashed on capture.
// Latency 1 cycle; valid/ready backpressure; depth 1 by default, depth 2 with the skid entry under MEM_WB_SKID_EN.
module mem_wb_pipe #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5,
    parameter int LANES  = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANES*DATA_W-1:0]   result_i,
    input  logic [LANES*ADDR_W-1:0]   reg_write_addr_i,
    input  logic [LANES-1:0]          reg_write_enable_i,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANES*DATA_W-1:0]   result_o,
    output logic [LANES*ADDR_W-1:0]   reg_write_addr_o,
    output logic [LANES-1:0]          reg_write_enable_o,
    output logic [1:0]                occupancy
);

    localparam int RW = LANES * DATA_W;
    localparam int AW = LANES * ADDR_W;

    logic           main_vld;
    logic [RW-1:0]  main_res;
    logic [AW-1:0]  main_addr;
    logic [LANES-1:0] main_we;
    logic [LANES-1:0] cap_we;
    logic           in_xfer;
    logic           main_free;

    // x0 writes are architecturally discarded, so drop the enable before it is stored
    always_comb begin
        cap_we = '0;
        for (int k = 0; k < LANES; k++) begin
            cap_we[k] = reg_write_enable_i[k] && (reg_write_addr_i[k*ADDR_W +: ADDR_W] != '0);
        end
    end

    assign in_xfer   = in_valid && in_ready;
    assign main_free = !main_vld || out_ready;

`ifdef MEM_WB_SKID_EN
    logic           skid_vld;
    logic [RW-1:0]  skid_res;
    logic [AW-1:0]  skid_addr;
    logic [LANES-1:0] skid_we;
    logic           rdy_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_vld  <= 1'b0;
            main_res  <= '0;
            main_addr <= '0;
            main_we   <= '0;
            skid_vld  <= 1'b0;
            skid_res  <= '0;
            skid_addr <= '0;
            skid_we   <= '0;
            rdy_q     <= 1'b1;
        end else if (flush) begin
            main_vld <= 1'b0;
            skid_vld <= 1'b0;
            rdy_q    <= 1'b1;
        end else if (main_free) begin
            // skid entry is older than anything arriving now, so it is promoted first
            if (skid_vld) begin
                main_res  <= skid_res;
                main_addr <= skid_addr;
                main_we   <= skid_we;
            end else if (in_xfer) begin
                main_res  <= result_i;
                main_addr <= reg_write_addr_i;
                main_we   <= cap_we;
            end
            main_vld <= skid_vld || in_xfer;
            if (skid_vld && in_xfer) begin
                skid_res  <= result_i;
                skid_addr <= reg_write_addr_i;
                skid_we   <= cap_we;
            end
            skid_vld <= skid_vld && in_xfer;
            rdy_q    <= !(skid_vld && in_xfer);
        end else if (in_xfer) begin
            skid_res  <= result_i;
            skid_addr <= reg_write_addr_i;
            skid_we   <= cap_we;
            skid_vld  <= 1'b1;
            rdy_q     <= 1'b0;
        end
    end

    assign in_ready  = rst_n && rdy_q;
    assign occupancy = {1'b0, main_vld} + {1'b0, skid_vld};
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_vld  <= 1'b0;
            main_res  <= '0;
            main_addr <= '0;
            main_we   <= '0;
        end else if (flush) begin
            main_vld <= 1'b0;
        end else if (main_free) begin
            // data registers only move on a real capture so idle outputs keep the last bundle
            if (in_xfer) begin
                main_res  <= result_i;
                main_addr <= reg_write_addr_i;
                main_we   <= cap_we;
            end
            main_vld <= in_xfer;
        end
    end

    assign in_ready  = rst_n && main_free;
    assign occupancy = {1'b0, main_vld};
`endif

    assign out_valid          = main_vld;
    assign result_o           = main_res;
    assign reg_write_addr_o   = main_addr;
    assign reg_write_enable_o = main_vld ? main_we : '0;

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Self-checking bench for mem_wb_pipe: directed table, corner sequences, random traffic against a queue model.
module tb_mem_wb_pipe;

`ifdef MEM_WB_SKID_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] result_i = '0;
    logic [4:0]  addr_i = '0;
    logic        we_i = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] result_o;
    logic [4:0]  addr_o;
    logic        we_o;
    logic [1:0]  occupancy;

    logic        flush2 = 1'b0;
    logic        in_valid2 = 1'b0;
    logic        in_ready2;
    logic [63:0] result_i2 = '0;
    logic [9:0]  addr_i2 = '0;
    logic [1:0]  we_i2 = '0;
    logic        out_valid2;
    logic        out_ready2 = 1'b1;
    logic [63:0] result_o2;
    logic [9:0]  addr_o2;
    logic [1:0]  we_o2;
    logic [1:0]  occupancy2;

    always #5 clk = ~clk;

    mem_wb_pipe u_dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .result_i(result_i), .reg_write_addr_i(addr_i), .reg_write_enable_i(we_i),
        .out_valid(out_valid), .out_ready(out_ready),
        .result_o(result_o), .reg_write_addr_o(addr_o), .reg_write_enable_o(we_o),
        .occupancy(occupancy)
    );

    mem_wb_pipe #(.DATA_W(32), .ADDR_W(5), .LANES(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .flush(flush2),
        .in_valid(in_valid2), .in_ready(in_ready2),
        .result_i(result_i2), .reg_write_addr_i(addr_i2), .reg_write_enable_i(we_i2),
        .out_valid(out_valid2), .out_ready(out_ready2),
        .result_o(result_o2), .reg_write_addr_o(addr_o2), .reg_write_enable_o(we_o2),
        .occupancy(occupancy2)
    );

    typedef struct {
        logic [63:0] res;
        logic [4:0]  addr;
        logic        we;
    } bun_t;

    typedef struct {
        logic        iv;
        logic [63:0] res;
        logic [4:0]  addr;
        logic        we;
        logic        ordy;
        logic        fl;
        logic        exp_ov;
        logic [63:0] exp_res;
        logic        exp_we;
        logic [1:0]  exp_occ;
    } vec_t;

    bun_t        q[$];
    logic [63:0] hold_res = '0;
    logic [4:0]  hold_addr = '0;
    int          checks = 0;
    int          failures = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    function automatic logic model_ready(input logic ordy);
        if (DEPTH == 2) return q.size() < 2;
        return (q.size() == 0) || ordy;
    endfunction

    task automatic check_model();
        chk("out_valid", {63'd0, out_valid}, {63'd0, q.size() > 0});
        chk("occupancy", {62'd0, occupancy}, 64'(q.size()));
        if (q.size() > 0) begin
            chk("result_o", result_o, q[0].res);
            chk("addr_o", {59'd0, addr_o}, {59'd0, q[0].addr});
            chk("we_o", {63'd0, we_o}, {63'd0, q[0].we});
            hold_res  = q[0].res;
            hold_addr = q[0].addr;
        end else begin
            chk("we_o_idle", {63'd0, we_o}, 64'd0);
            chk("result_o_hold", result_o, hold_res);
            chk("addr_o_hold", {59'd0, addr_o}, {59'd0, hold_addr});
        end
    endtask

    // Called on a falling edge; returns on the next falling edge.
    task automatic cycle(input logic iv, input logic [63:0] res, input logic [4:0] addr,
                         input logic we, input logic ordy, input logic fl);
        bun_t b;
        logic push, pop;
        in_valid = iv; result_i = res; addr_i = addr; we_i = we; out_ready = ordy; flush = fl;
        #1;
        chk("in_ready", {63'd0, in_ready}, {63'd0, model_ready(ordy)});
        push = iv && model_ready(ordy);
        pop  = (q.size() > 0) && ordy;
        b.res = res; b.addr = addr; b.we = we && (addr != 5'd0);
        @(posedge clk);
        if (fl) q.delete();
        else begin
            if (pop) void'(q.pop_front());
            if (push) q.push_back(b);
        end
        @(negedge clk);
        check_model();
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = '{1'b1, 64'hDEAD_BEEF, 5'd3,  1'b1, 1'b1, 1'b0, 1'b1, 64'hDEAD_BEEF, 1'b1, 2'd1};
        vecs[1] = '{1'b1, 64'h1234,      5'd0,  1'b1, 1'b1, 1'b0, 1'b1, 64'h1234,      1'b0, 2'd1};
        vecs[2] = '{1'b1, 64'h55,        5'd31, 1'b0, 1'b1, 1'b0, 1'b1, 64'h55,        1'b0, 2'd1};
        vecs[3] = '{1'b1, 64'hAA,        5'd7,  1'b1, 1'b1, 1'b1, 1'b0, 64'h55,        1'b0, 2'd0};
        vecs[4] = '{1'b0, 64'h0,         5'd0,  1'b0, 1'b1, 1'b0, 1'b0, 64'h55,        1'b0, 2'd0};
        vecs[5] = '{1'b1, 64'h77,        5'd1,  1'b1, 1'b0, 1'b0, 1'b1, 64'h77,        1'b1, 2'd1};
        vecs[6] = '{1'b0, 64'h99,        5'd2,  1'b1, 1'b0, 1'b0, 1'b1, 64'h77,        1'b1, 2'd1};
        vecs[7] = '{1'b0, 64'h0,         5'd0,  1'b0, 1'b1, 1'b0, 1'b0, 64'h77,        1'b0, 2'd0};

        // reset state, checked with no clock edge involved
        #3;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_occupancy", {62'd0, occupancy}, 64'd0);
        chk("rst_result_o", result_o, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);

        for (int i = 0; i < 8; i++) begin
            cycle(vecs[i].iv, vecs[i].res, vecs[i].addr, vecs[i].we, vecs[i].ordy, vecs[i].fl);
            chk($sformatf("vec%0d_ov", i), {63'd0, out_valid}, {63'd0, vecs[i].exp_ov});
            chk($sformatf("vec%0d_res", i), result_o, vecs[i].exp_res);
            chk($sformatf("vec%0d_we", i), {63'd0, we_o}, {63'd0, vecs[i].exp_we});
            chk($sformatf("vec%0d_occ", i), {62'd0, occupancy}, {62'd0, vecs[i].exp_occ});
        end

`ifdef MEM_WB_SKID_EN
        // stalled main entry: second bundle lands in the skid entry, both drain in order
        cycle(1'b1, 64'hA, 5'd4, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 64'hB, 5'd5, 1'b1, 1'b0, 1'b0);
        chk("skid_occ2", {62'd0, occupancy}, 64'd2);
        chk("skid_in_ready0", {63'd0, in_ready}, 64'd0);
        cycle(1'b0, 64'h0, 5'd0, 1'b0, 1'b1, 1'b0);
        chk("skid_first_B", result_o, 64'hB);
        cycle(1'b0, 64'h0, 5'd0, 1'b0, 1'b1, 1'b0);
        chk("skid_drained", {63'd0, out_valid}, 64'd0);
`endif

        // reset dropped between edges while full
        cycle(1'b1, 64'hC0FFEE, 5'd9, 1'b1, 1'b0, 1'b0);
        if (DEPTH == 2) cycle(1'b1, 64'hBEE, 5'd10, 1'b1, 1'b0, 1'b0);
        chk("full_occ", {62'd0, occupancy}, 64'(DEPTH));
        in_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("mid_rst_occ", {62'd0, occupancy}, 64'd0);
        chk("mid_rst_result", result_o, 64'd0);
        chk("mid_rst_addr", {59'd0, addr_o}, 64'd0);
        chk("mid_rst_we", {63'd0, we_o}, 64'd0);
        chk("mid_rst_in_ready", {63'd0, in_ready}, 64'd0);
        q.delete();
        hold_res = '0;
        hold_addr = '0;
        #1 rst_n = 1'b1;
        #1;
        chk("rel_in_ready", {63'd0, in_ready}, 64'd1);
        @(negedge clk);

        // two-lane packing and per-lane squash
        in_valid2 = 1'b1;
        result_i2 = {32'h22, 32'h11};
        addr_i2   = {5'd0, 5'd7};
        we_i2     = 2'b11;
        @(posedge clk);
        @(negedge clk);
        in_valid2 = 1'b0;
        chk("l2_valid", {63'd0, out_valid2}, 64'd1);
        chk("l2_result", result_o2, {32'h22, 32'h11});
        chk("l2_addr", {54'd0, addr_o2}, {54'd0, 5'd0, 5'd7});
        chk("l2_we", {62'd0, we_o2}, 64'd1);

        // random traffic against the queue model
        for (int n = 0; n < 500; n++) begin
            logic [4:0] a;
            a = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            cycle(1'($urandom_range(0, 1)), {$urandom, $urandom}, a, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_wb_pipe.md
MEM_WB_PIPE -- requirements
Module: mem_wb_pipe

Interface
REQ-001 Parameter DATA_W, default 64, width of one lane's result.
REQ-002 Parameter ADDR_W, default 5, width of one lane's register-file write address.
REQ-003 Parameter LANES, default 1, number of parallel writeback lanes that move as one bundle.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 flush  input  1  synchronous pipeline flush, drops all held entries.
REQ-007 in_valid  input  1  upstream bundle valid.
REQ-008 in_ready  output  1  block can accept a bundle this cycle.
REQ-009 result_i  input  LANES*DATA_W  lane results, lane k at bits [k*DATA_W +: DATA_W].
REQ-010 reg_write_addr_i  input  LANES*ADDR_W  lane write addresses, same packing.
REQ-011 reg_write_enable_i  input  LANES  per-lane write enables.
REQ-012 out_valid  output  1  output bundle valid.
REQ-013 out_ready  input  1  downstream accepts the bundle.
REQ-014 result_o  output  LANES*DATA_W  held lane results.
REQ-015 reg_write_addr_o  output  LANES*ADDR_W  held lane addresses.
REQ-016 reg_write_enable_o  output  LANES  held per-lane enables, qualified by out_valid.
REQ-017 occupancy  output  2  number of bundles held (0..2).

Function
REQ-018 An input transfer SHALL occur on a rising edge where in_valid and in_ready are both 1; an output transfer SHALL occur where out_valid and out_ready are both 1.
REQ-019 A bundle accepted at edge N SHALL appear on the outputs with out_valid=1 immediately after edge N (latency 1 cycle).
REQ-020 Bundles SHALL leave in acceptance order; none SHALL be dropped or duplicated except by flush or reset.
REQ-021 While out_valid=1 and out_ready=0, all data outputs SHALL remain stable.
REQ-022 On capture, lane k enable SHALL be forced to 0 when lane k address is 0 (x0 write squash).
REQ-023 reg_write_enable_o SHALL be all-zero whenever out_valid=0; result_o and reg_write_addr_o SHALL hold their last values.
REQ-024 At occupancy 1, a simultaneous input and output transfer SHALL leave occupancy at 1 with the new bundle on the outputs.
REQ-025 occupancy SHALL increment on input-only transfer, decrement on output-only transfer, and never exceed the configured depth.
REQ-026 flush=1 SHALL have priority over all transfers: after the edge, occupancy=0, out_valid=0, and any concurrent input bundle SHALL be discarded.
REQ-027 in_valid SHALL be ignored while in_ready=0.

Reset
REQ-028 rst_n=0 SHALL immediately, without a clock edge, force out_valid=0, occupancy=0, and result_o, reg_write_addr_o and reg_write_enable_o to all zeros.
REQ-029 While rst_n=0, in_ready SHALL be 0; after release, in_ready SHALL be 1 on the first cycle.
REQ-030 Reset asserted mid-transfer SHALL discard all held bundles.

Configuration
REQ-031 With MEM_WB_SKID_EN defined, depth SHALL be 2 (main plus skid entry) and in_ready SHALL be a registered signal equal to (occupancy<2).
REQ-032 With MEM_WB_SKID_EN defined, bundles arriving while the main entry stalls SHALL be stored in the skid entry and promoted when the main entry drains.
REQ-033 Without MEM_WB_SKID_EN, depth SHALL be 1, in_ready SHALL be combinational (!out_valid || out_ready), and occupancy SHALL never exceed 1.

Verification
REQ-034 Reset, then push result=64'hDEAD_BEEF, addr=5'd3, we=1 with out_ready=1 -> next cycle out_valid=1, result_o=DEAD_BEEF, addr=3, we=1.
REQ-035 Push addr=0, we=1 -> reg_write_enable_o=0 while out_valid=1.
REQ-036 SKID_EN: hold out_ready=0 and push A then B -> occupancy=2 and in_ready=0; release out_ready -> A then B on consecutive cycles.
REQ-037 occupancy=1 with in_valid=1, out_ready=1 and flush=1 -> next cycle occupancy=0, out_valid=0, and the pushed bundle is never output.
REQ-038 Drop rst_n between clock edges while occupancy=2 -> outputs are zero before the next edge and in_ready=1 after release.
REQ-039 LANES=2, DATA_W=32: push lane0=(0x11, 7, 1) and lane1=(0x22, 0, 1) -> lane0 we=1 and lane1 we=0, with correct bit packing.
